seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 81 ++++++++
 tb/tb_seq_divider.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential non-restoring divider, signed or unsigned, one quotient bit per CALC cycle.
// Status outputs are registered from the state, so they appear one cycle after the state they report.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [N:0]    pr, dm, pr_sh, pr_nx, dm_in;
  logic [N-1:0]  dq, dv_mag, rem_mag, q_out, r_out;
  logic          sop, dsgn, vsgn, accept;
  always_comb begin
    accept  = start && (state == IDLE || state == DONE);
    dv_mag  = (signed_op && dividend[N-1]) ? -dividend : dividend;
    dm_in   = {1'b0, (signed_op && divisor[N-1]) ? -divisor : divisor};
    pr_sh   = {pr[N-1:0], dq[N-1]};
    pr_nx   = pr[N] ? pr_sh + dm : pr_sh - dm;
    rem_mag = pr[N] ? pr[N-1:0] + dm[N-1:0] : pr[N-1:0];
    q_out   = (sop && (dsgn ^ vsgn)) ? -dq : dq;
    r_out   = (sop && dsgn) ? -rem_mag : rem_mag;
  end
  // dq shifts dividend bits out of its MSB while quotient bits fill in from the LSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dm          <= '0;
      dq          <= '0;
      sop         <= 1'b0;
      dsgn        <= 1'b0;
      vsgn        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= state == CALC || state == FIXUP;
      done <= state == DONE;
      if (accept) begin
        sop         <= signed_op;
        dsgn        <= dividend[N-1];
        vsgn        <= divisor[N-1];
        dq          <= dv_mag;
        dm          <= dm_in;
        pr          <= '0;
        cnt         <= '0;
        state       <= (divisor == '0) ? DONE : CALC;
        div_by_zero <= divisor == '0;
        if (divisor == '0) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end else if (state == CALC) begin
        pr    <= pr_nx;
        dq    <= {dq[N-2:0], ~pr_nx[N]};
        cnt   <= cnt + 1'b1;
        state <= (cnt == CW'(N - 1)) ? FIXUP : CALC;
      end else if (state == FIXUP) begin
        quotient  <= q_out;
        remainder <= r_out;
        state     <= DONE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
  localparam int N = 32;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, signed_op = 1'b0;
  logic [N-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;
  int           vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  function automatic void ref_div(input logic [N-1:0] a, b, input logic s,
                                  output logic [N-1:0] q, r, output logic dz);
    longint sa, sb;
    dz = (b == '0);
    if (dz) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = N'(sa / sb);
      r  = N'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic check(input string name, input logic [N-1:0] got, want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // reference timing: an accepted op completes N+2 edges later (1 for a zero divisor)
  int           ec = 0, retired = -1, free_edge = 0, acc_edge = 0, done_edge = 0;
  bit           pend = 1'b0;
  logic         pdz = 1'b0, edz = 1'b0;
  logic [N-1:0] pq = '0, prr = '0, eq = '0, er = '0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend = 1'b0; eq = '0; er = '0; edz = 1'b0; retired = -1; free_edge = 0;
    end else begin
      ec++;
      if (pend && ec == done_edge) begin
        eq = pq; er = prr; edz = pdz; retired = ec; pend = 1'b0;
      end
      if (start && ec >= free_edge) begin
        ref_div(dividend, divisor, signed_op, pq, prr, pdz);
        acc_edge  = ec;
        done_edge = ec + (pdz ? 1 : N + 2);
        free_edge = done_edge;
        pend      = 1'b1;
      end
    end

  always @(negedge clk) begin
    check("busy", N'(busy), N'(pend && !pdz && ec >= acc_edge + 1 && ec <= acc_edge + N + 1));
    check("done", N'(done), N'(retired == ec));
    if (!pend || retired == ec) begin
      check("quotient", quotient, eq);
      check("remainder", remainder, er);
      check("div_by_zero", N'(div_by_zero), N'(edz));
    end
  end

  task automatic go(input logic [N-1:0] a, b, input logic s);
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    @(posedge clk); #2;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (done) return;
      lat++;
      if (lat > 200) begin
        vectors++; miscompares++;
        $display("FAIL timeout: done not seen, got 0, want 1");
        return;
      end
    end
  endtask

  task automatic run(input string name, input logic [N-1:0] a, b, input logic s,
                     input logic [N-1:0] wq, wr, input logic wdz, input int wlat);
    int lat;
    go(a, b, s);
    wait_done(lat);
    check({name, " q"}, quotient, wq);
    check({name, " r"}, remainder, wr);
    check({name, " dz"}, N'(div_by_zero), N'(wdz));
    check({name, " latency"}, N'(lat), N'(wlat));
  endtask

  initial begin
    logic [N-1:0] q, r, a, b;
    logic dz, s;
    int lat;
    ref_div(100, 7, 1'b0, q, r, dz);
    check("model 100/7 q", q, 14); check("model 100/7 r", r, 2);
    ref_div(-100, 7, 1'b1, q, r, dz);
    check("model -100/7 q", q, 32'hFFFFFFF2); check("model -100/7 r", r, 32'hFFFFFFFE);
    ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1, q, r, dz);
    check("model ovf q", q, 32'h80000000); check("model ovf r", r, 0);
    ref_div(5, 0, 1'b1, q, r, dz);
    check("model dz q", q, 32'hFFFFFFFF); check("model dz flag", N'(dz), 1);
    repeat (3) @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    run("u 100/7", 100, 7, 1'b0, 14, 2, 1'b0, 34);
    run("s -100/7", -100, 7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
    run("s 100/-7", 100, -7, 1'b1, 32'hFFFFFFF2, 2, 1'b0, 34);
    run("s -100/-7", -100, -7, 1'b1, 14, 32'hFFFFFFFE, 1'b0, 34);
    run("s ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 0, 1'b0, 34);
    run("u big", 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 32'h80000000, 1'b0, 34);
    run("u max/1", 32'hFFFFFFFF, 1, 1'b0, 32'hFFFFFFFF, 0, 1'b0, 34);
    run("u 5/0", 5, 0, 1'b0, 32'hFFFFFFFF, 5, 1'b1, 1);
    run("s 5/0", 5, 0, 1'b1, 32'hFFFFFFFF, 5, 1'b1, 1);
    run("clear dz", 100, 7, 1'b0, 14, 2, 1'b0, 34);
    go(1000, 3, 1'b0);
    repeat (5) @(posedge clk);
    #2 start = 1'b1; dividend = 7; divisor = 1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(lat);
    check("busy-start q", quotient, 333); check("busy-start r", remainder, 1);
    check("busy-start latency", N'(lat), 28);
    go(100, 7, 1'b0);
    start = 1'b1; dividend = 81; divisor = 9; signed_op = 1'b0;
    wait_done(lat);
    start = 1'b0;
    check("b2b first q", quotient, 14);
    wait_done(lat);
    check("b2b second q", quotient, 9); check("b2b second r", remainder, 0);
    check("b2b latency", N'(lat), 33);
    go(100, 7, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset busy", N'(busy), 0); check("reset q", quotient, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run("post-reset 81/9", 81, 9, 1'b0, 9, 0, 1'b0, 34);
    for (int i = 0; i < 250; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 1;
        2: b = '1;
        3: b = $urandom_range(1, 20);
        4: a = 32'h80000000;
        5: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40) * (s ? -1 : 1); end
        default: ;
      endcase
      go(a, b, s);
      wait_done(lat);
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
